// File: rtl/rib_sram_slave.sv
// rib_sram_slave
//   RIB bus responder in front of a single-port, byte-maskable 32-bit word
//   SRAM. Only one transfer is in flight at a time. An accepted transfer
//   waits WAIT cycles, then performs the SRAM access. Its response is held
//   until the master is ready. With WAIT=0, a response can be consumed and
//   the next request accepted on the same edge, giving one transfer/cycle.
//
// Parameters
//   ADDR_W : word-address bits (capacity 2^ADDR_W words)
//   WAIT   : wait cycles between acceptance and SRAM access (0..15)
//
// Ports
//   i_clk, i_rstn  : clock (rising edge), asynchronous active-low reset
//   i_ribs_addr    : byte address; bits [ADDR_W+1:2] select the word
//   i_ribs_wrcs    : 1 = write, 0 = read
//   i_ribs_mask    : per-byte write enables
//   i_ribs_wdata   : write data
//   i_ribs_req     : request valid        o_ribs_gnt : grant
//   o_ribs_rsp     : response valid       i_ribs_rdy : master ready
//   o_ribs_rdata   : read data (0 for writes), valid while o_ribs_rsp=1
module rib_sram_slave #(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_ribs_addr,
  input  logic        i_ribs_wrcs,
  input  logic [3:0]  i_ribs_mask,
  input  logic [31:0] i_ribs_wdata,
  output logic [31:0] o_ribs_rdata,
  input  logic        i_ribs_req,
  output logic        o_ribs_gnt,
  output logic        o_ribs_rsp,
  input  logic        i_ribs_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT);
  localparam bit         NO_WAIT = (WAIT == 0);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q;

  // Request latched at acceptance, used when the access is deferred by WAIT.
  logic [ADDR_W-1:0] idx_p0;
  logic              wr_p0;
  logic [3:0]        mask_p0;
  logic [31:0]       wdata_p0;

  logic              accept;
  logic              wait_done;
  logic              access;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_wr;
  logic [3:0]        acc_mask;
  logic [31:0]       acc_wdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  // Upper and byte-offset address bits are intentionally ignored (aliasing).
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{i_ribs_addr[31:ADDR_W+2], i_ribs_addr[1:0]};

  assign accept     = i_ribs_req && o_ribs_gnt;
  assign wait_done  = (state_q == BUSY) && (wait_cnt_q == 4'd1);
  // With no wait states the access happens on the accept edge itself.
  assign access     = (accept && NO_WAIT) || wait_done;
  assign o_ribs_rsp = (state_q == RESP);

  // Grant is forced low while reset is held, regardless of state.
  always_comb begin
    o_ribs_gnt = 1'b0;
    if (i_rstn) begin
      case (state_q)
        IDLE:    o_ribs_gnt = 1'b1;
        RESP:    o_ribs_gnt = i_ribs_rdy;
        default: o_ribs_gnt = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (NO_WAIT) state_d = RESP;
          else         state_d = BUSY;
        end
      end
      BUSY: begin
        if (wait_done) state_d = RESP;
      end
      RESP: begin
        if (i_ribs_rdy) begin
          if (!accept)      state_d = IDLE;
          else if (NO_WAIT) state_d = RESP;
          else              state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Deferred accesses use the latched request; immediate ones use the bus.
  always_comb begin
    if (state_q == BUSY) begin
      acc_idx   = idx_p0;
      acc_wr    = wr_p0;
      acc_mask  = mask_p0;
      acc_wdata = wdata_p0;
    end else begin
      acc_idx   = i_ribs_addr[ADDR_W+1:2];
      acc_wr    = i_ribs_wrcs;
      acc_mask  = i_ribs_mask;
      acc_wdata = i_ribs_wdata;
    end
  end

  // Stage p0: acceptance latch, wait counter, response register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      idx_p0       <= '0;
      wr_p0        <= 1'b0;
      mask_p0      <= 4'd0;
      wdata_p0     <= 32'd0;
      o_ribs_rdata <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_p0     <= i_ribs_addr[ADDR_W+1:2];
        wr_p0      <= i_ribs_wrcs;
        mask_p0    <= i_ribs_mask;
        wdata_p0   <= i_ribs_wdata;
        wait_cnt_q <= WAIT_LD;
      end else if (state_q == BUSY) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      if (access) begin
        o_ribs_rdata <= acc_wr ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Stage p1: SRAM byte-lane write (contents survive reset)
  always_ff @(posedge i_clk) begin
    if (access && acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rib_sram_slave.sv
module tb_rib_sram_slave;

  logic        clk;
  logic [1:0]  rstn;
  logic [1:0]  req;
  logic [1:0]  rdy;
  logic [1:0]  wrcs;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  mask  [2];

  logic        gnt_w0, gnt_w1, rsp_w0, rsp_w1;
  logic [31:0] rdata_w0, rdata_w1;
  logic        gnt   [2];
  logic        rsp   [2];
  logic [31:0] rdata [2];

  int tests = 0;
  int fails = 0;

  // Instance 0 has no wait states, instance 1 has three.
  rib_sram_slave #(.ADDR_W(12), .WAIT(0)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_ribs_addr(addr[0]), .i_ribs_wrcs(wrcs[0]),
    .i_ribs_mask(mask[0]), .i_ribs_wdata(wdata[0]), .o_ribs_rdata(rdata_w0),
    .i_ribs_req(req[0]), .o_ribs_gnt(gnt_w0), .o_ribs_rsp(rsp_w0), .i_ribs_rdy(rdy[0])
  );

  rib_sram_slave #(.ADDR_W(12), .WAIT(3)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_ribs_addr(addr[1]), .i_ribs_wrcs(wrcs[1]),
    .i_ribs_mask(mask[1]), .i_ribs_wdata(wdata[1]), .o_ribs_rdata(rdata_w1),
    .i_ribs_req(req[1]), .o_ribs_gnt(gnt_w1), .o_ribs_rsp(rsp_w1), .i_ribs_rdy(rdy[1])
  );

  always_comb begin
    gnt[0] = gnt_w0;  gnt[1] = gnt_w1;
    rsp[0] = rsp_w0;  rsp[1] = rsp_w1;
    rdata[0] = rdata_w0;  rdata[1] = rdata_w1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: an accepted transfer is served WAIT edges after
  // its accept edge; its response then stays up until rsp & rdy.
  logic        m_pend [2];
  logic        m_rv   [2];
  logic [31:0] m_rd   [2];
  int          m_acc_t[2];
  logic [11:0] m_idx  [2];
  logic        m_wr   [2];
  logic [3:0]  m_mask [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_mem  [2][4096];
  int          cyc = 0;

  function automatic int wt(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic gnt_exp(input int d);
    if (!rstn[d])  return 1'b0;
    if (m_rv[d])   return rdy[d];
    return !m_pend[d];
  endfunction

  task automatic m_access(input int d);
    if (m_wr[d]) begin
      for (int b = 0; b < 4; b++)
        if (m_mask[d][b]) m_mem[d][m_idx[d]][8*b +: 8] = m_wd[d][8*b +: 8];
      m_rd[d] = 32'd0;
    end else begin
      m_rd[d] = m_mem[d][m_idx[d]];
    end
    m_rv[d] = 1'b1;
  endtask

  task automatic m_edge(input int d);
    logic g;
    if (!rstn[d]) begin
      m_pend[d] = 1'b0;
      m_rv[d]   = 1'b0;
    end else begin
      g = gnt_exp(d);
      if (m_rv[d] && rdy[d]) m_rv[d] = 1'b0;
      if (m_pend[d] && cyc == m_acc_t[d]) begin
        m_access(d);
        m_pend[d] = 1'b0;
      end
      if (req[d] && g) begin
        m_idx[d]  = addr[d][13:2];
        m_wr[d]   = wrcs[d];
        m_mask[d] = mask[d];
        m_wd[d]   = wdata[d];
        if (wt(d) == 0) m_access(d);
        else begin
          m_pend[d]  = 1'b1;
          m_acc_t[d] = cyc + wt(d);
        end
      end
    end
  endtask

  task automatic m_check(input int d);
    if (!rstn[d]) begin
      chk($sformatf("rst_rsp%0d", d), 32'(rsp[d]), 32'd0);
      chk($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
    end else begin
      chk($sformatf("model_rsp%0d", d), 32'(rsp[d]), 32'(m_rv[d]));
      chk($sformatf("model_gnt%0d", d), 32'(gnt[d]), 32'(gnt_exp(d)));
      if (m_rv[d]) chk($sformatf("model_rdata%0d", d), rdata[d], m_rd[d]);
    end
  endtask

  // Compare process: update model on the active edge, check on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      m_edge(0);
      m_edge(1);
      cyc++;
      @(negedge clk);
      m_check(0);
      m_check(1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] m,
                      input logic [31:0] wd, output logic [31:0] rdat, output int lat);
    int n;
    rdat = 32'd0;
    lat  = -1;
    @(posedge clk); #1;
    addr[d] = a; wrcs[d] = w; mask[d] = m; wdata[d] = wd; req[d] = 1'b1; rdy[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!gnt[d] && n < 50) begin @(negedge clk); n++; end
    if (!gnt[d]) begin
      chk("accept_timeout", 32'(gnt[d]), 32'd1);
      req[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
    lat = 0;
    while (!rsp[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp[d]) begin
      chk("rsp_timeout", 32'(rsp[d]), 32'd1);
      return;
    end
    rdat = rdata[d];
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          lat;
  logic [31:0] v [4];

  initial begin
    rstn = 2'b00; req = 2'b00; rdy = 2'b11; wrcs = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 32'd0; wdata[d] = 32'd0; mask[d] = 4'd0;
    end
    v[0] = 32'h1111_0001; v[1] = 32'h2222_0002; v[2] = 32'h3333_0003; v[3] = 32'h4444_0004;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp", 32'(rsp[0]), 32'd0);
    chk("reset_gnt", 32'(gnt[0]), 32'd0);
    rstn = 2'b11;
    #1;
    chk("post_reset_gnt0", 32'(gnt[0]), 32'd1);
    chk("post_reset_gnt1", 32'(gnt[1]), 32'd1);

    // 1: full write then read, WAIT=0
    xfer(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, lat);
    chk("t1_wr_rdata", rd, 32'd0);
    chk("t1_wr_lat", 32'(lat), 32'd0);
    xfer(0, 32'h10, 1'b0, 4'h0, 32'd0, rd, lat);
    chk("t1_rd_rdata", rd, 32'hDEADBEEF);
    chk("t1_rd_lat", 32'(lat), 32'd0);

    // 2: byte-masked write
    xfer(0, 32'h10, 1'b1, 4'b0101, 32'h11223344, rd, lat);
    xfer(0, 32'h10, 1'b0, 4'hF, 32'd0, rd, lat);
    chk("t2_mask_rdata", rd, 32'hDE22BE44);

    // 3: backpressure; bus inputs wiggle while the response is held
    @(posedge clk); #1;
    addr[0] = 32'h10; wrcs[0] = 1'b0; req[0] = 1'b1; rdy[0] = 1'b0;
    @(posedge clk); #1;
    req[0] = 1'b0; addr[0] = 32'hFFFF_FFFC; wrcs[0] = 1'b1; wdata[0] = 32'h0BAD0BAD; mask[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_rsp", 32'(rsp[0]), 32'd1);
      chk("t3_hold_rdata", rdata[0], 32'hDE22BE44);
      chk("t3_hold_gnt", 32'(gnt[0]), 32'd0);
      @(posedge clk); #1;
    end
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("t3_idle_rsp", 32'(rsp[0]), 32'd0);
    chk("t3_idle_gnt", 32'(gnt[0]), 32'd1);

    // write with empty mask leaves the word alone
    xfer(0, 32'h10, 1'b1, 4'h0, 32'h00000000, rd, lat);
    chk("mask0_wr_rdata", rd, 32'd0);
    xfer(0, 32'h10, 1'b0, 4'hF, 32'd0, rd, lat);
    chk("mask0_rd_rdata", rd, 32'hDE22BE44);

    // 4a: WAIT=3 latency
    xfer(1, 32'h40, 1'b1, 4'hF, 32'hCAFEF00D, rd, lat);
    chk("t4_wr_lat", 32'(lat), 32'd3);
    xfer(1, 32'h40, 1'b0, 4'hF, 32'd0, rd, lat);
    chk("t4_rd_lat", 32'(lat), 32'd3);
    chk("t4_rd_rdata", rd, 32'hCAFEF00D);

    // 4b: back-to-back reads at WAIT=0
    for (int k = 0; k < 4; k++) xfer(0, 32'h100 + 32'(4*k), 1'b1, 4'hF, v[k], rd, lat);
    @(posedge clk); #1;
    addr[0] = 32'h100; wrcs[0] = 1'b0; req[0] = 1'b1; rdy[0] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t4_b2b_rsp", 32'(rsp[0]), 32'd1);
      chk("t4_b2b_rdata", rdata[0], v[k-1]);
      addr[0] = 32'h100 + 32'(4*k);
    end
    @(posedge clk); #1;
    chk("t4_b2b_rsp", 32'(rsp[0]), 32'd1);
    chk("t4_b2b_rdata", rdata[0], v[3]);
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("t4_b2b_end_rsp", 32'(rsp[0]), 32'd0);

    // 5: address aliasing
    xfer(0, 32'h00004008, 1'b1, 4'hF, 32'hA5A5A5A5, rd, lat);
    xfer(0, 32'h00000008, 1'b0, 4'hF, 32'd0, rd, lat);
    chk("t5_alias_rdata", rd, 32'hA5A5A5A5);
    xfer(0, 32'h0000000B, 1'b0, 4'hF, 32'd0, rd, lat);
    chk("t5_misalign_rdata", rd, 32'hA5A5A5A5);

    // 6: reset during BUSY drops the pending write
    xfer(1, 32'h20, 1'b1, 4'hF, 32'h0BADF00D, rd, lat);
    @(posedge clk); #1;
    addr[1] = 32'h20; wrcs[1] = 1'b1; mask[1] = 4'hF; wdata[1] = 32'h12345678; req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    chk("t6_rst_rsp", 32'(rsp[1]), 32'd0);
    chk("t6_rst_gnt", 32'(gnt[1]), 32'd0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    xfer(1, 32'h20, 1'b0, 4'hF, 32'd0, rd, lat);
    chk("t6_rd_rdata", rd, 32'h0BADF00D);
    chk("t6_rd_lat", 32'(lat), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
